// File: rtl/ysyx_25010008_lsu_pkg.sv
// Shared LSU definitions: FSM state codes, RV funct3 load/store ops, access lengths.
// Pure definitions: no latency and no backpressure of their own.
package ysyx_25010008_lsu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  // Illegal size encoding 11 falls into the word case.
  function automatic logic [2:0] len_of(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return LEN_B;
      2'b01:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

  function automatic logic [31:0] store_mask(input logic [2:0] len, input logic [31:0] d);
    case (len)
      LEN_B:   return {24'h0, d[7:0]};
      LEN_H:   return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_25010008_lsu_mem_master_if.sv
// Core request/response handshake plus SRAM model strobes bundled into one bus.
// Signals only: latency and backpressure belong to the master that drives it.
interface ysyx_25010008_lsu_mem_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ren;
  logic [31:0] raddr;
  logic        wen;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [2:0]  len;
  logic [31:0] rdata;

  modport master (
    input  req_valid, req_wen, req_op, req_addr, req_wdata, resp_ready, rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output ren, raddr, wen, waddr, wdata, len
  );

  modport slave (
    output req_valid, req_wen, req_op, req_addr, req_wdata, resp_ready, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  ren, raddr, wen, waddr, wdata, len
  );
endinterface

// File: rtl/ysyx_25010008_load_ext.sv
// Load result extension from funct3: b/h sign-extend, bu/hu zero-extend, else pass-through.
// Combinational, zero latency, no backpressure.
module ysyx_25010008_load_ext
  import ysyx_25010008_lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (op)
      OP_B:    ext = {{24{raw[7]}}, raw[7:0]};
      OP_H:    ext = {{16{raw[15]}}, raw[15:0]};
      OP_BU:   ext = {24'h0, raw[7:0]};
      OP_HU:   ext = {16'h0, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/ysyx_25010008_lsu_mem_master.sv
// One-at-a-time LSU master to the SRAM model; load resp RD_LATENCY+2 cycles after accept, store 2; resp held until resp_ready.
// LSU_MISALIGN_TRAP_EN: misaligned h/w accesses skip the memory and respond with resp_err=1.
module ysyx_25010008_lsu_mem_master
  import ysyx_25010008_lsu_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1
) (
  input logic                               clk,
  input logic                               rst_n,
  ysyx_25010008_lsu_mem_master_if.master    bus
);

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [2:0]  req_len;
  logic        misalign;
  logic [31:0] ext_data;

  assign req_len = len_of(bus.req_op);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_len == LEN_H) && bus.req_addr[0]) ||
                    ((req_len == LEN_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  ysyx_25010008_load_ext u_load_ext (
    .op  (op_q),
    .raw (bus.rdata),
    .ext (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    ren_d        = 1'b0;
    wen_d        = 1'b0;
    raddr_d      = raddr_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    len_d        = len_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d         = bus.req_op;
          len_d        = req_len;
          resp_rdata_d = 32'h0;
          resp_err_d   = misalign;
          if (misalign) begin
            state_d = ST_RESP;
          end else if (bus.req_wen) begin
            wen_d   = 1'b1;
            waddr_d = bus.req_addr;
            wdata_d = store_mask(req_len, bus.req_wdata);
            state_d = ST_ISSUE;
          end else begin
            ren_d   = 1'b1;
            raddr_d = bus.req_addr;
            state_d = ST_ISSUE;
          end
        end
      end
      // The strobe is registered, so ren_q marks a load during this cycle.
      ST_ISSUE: begin
        if (ren_q) begin
          cnt_d   = 3'(RD_LATENCY - 1);
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) begin
          resp_rdata_d = ext_data;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'd0;
      cnt_q        <= 3'd0;
      ren_q        <= 1'b0;
      wen_q        <= 1'b0;
      raddr_q      <= 32'h0;
      waddr_q      <= 32'h0;
      wdata_q      <= 32'h0;
      len_q        <= 3'd0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      ren_q        <= ren_d;
      wen_q        <= wen_d;
      raddr_q      <= raddr_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      len_q        <= len_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.ren        = ren_q;
  assign bus.raddr      = raddr_q;
  assign bus.wen        = wen_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.len        = len_q;

endmodule

// File: tb/tb_ysyx_25010008_lsu_mem_master.sv
// Directed bench for the LSU memory master with a 1-cycle SRAM responder.
module tb_ysyx_25010008_lsu_mem_master;
  import ysyx_25010008_lsu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  ysyx_25010008_lsu_mem_master_if bus ();

  ysyx_25010008_lsu_mem_master #(.RD_LATENCY(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: data valid only in the cycle after a ren, junk otherwise.
  logic [31:0] rd_val;
  always @(posedge clk) bus.rdata <= bus.ren ? rd_val : 32'hDEAD_0BAD;

  int          ren_cnt = 0, wen_cnt = 0, both_cnt = 0;
  logic [31:0] r_addr_seen, w_addr_seen, w_data_seen;
  logic [2:0]  r_len_seen, w_len_seen;
  always @(negedge clk) begin
    if (bus.ren) begin ren_cnt++; r_addr_seen = bus.raddr; r_len_seen = bus.len; end
    if (bus.wen) begin wen_cnt++; w_addr_seen = bus.waddr; w_data_seen = bus.wdata; w_len_seen = bus.len; end
    if (bus.ren && bus.wen) both_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic w, input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    bus.req_valid = 1'b1; bus.req_wen = w; bus.req_op = op; bus.req_addr = a; bus.req_wdata = d;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!bus.resp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic load_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] memv, input logic [31:0] exp_rd, input logic [2:0] exp_len);
    int r0, w0, cyc;
    r0 = ren_cnt; w0 = wen_cnt; rd_val = memv;
    send(1'b0, op, a, 32'hFFFF_FFFF);
    wait_resp(cyc);
    chk({tag, "_latency"}, cyc, 3);
    chk({tag, "_rdata"}, bus.resp_rdata, exp_rd);
    chk({tag, "_err"}, bus.resp_err, 0);
    chk({tag, "_ren_pulses"}, ren_cnt - r0, 1);
    chk({tag, "_wen_pulses"}, wen_cnt - w0, 0);
    chk({tag, "_len"}, r_len_seen, exp_len);
    chk({tag, "_raddr"}, r_addr_seen, a);
    ack();
    chk({tag, "_idle_ready"}, bus.req_ready, 1);
  endtask

  task automatic store_case(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] exp_wd, input logic [2:0] exp_len);
    int r0, w0, cyc;
    r0 = ren_cnt; w0 = wen_cnt;
    send(1'b1, op, a, d);
    wait_resp(cyc);
    chk({tag, "_latency"}, cyc, 2);
    chk({tag, "_rdata"}, bus.resp_rdata, 0);
    chk({tag, "_wen_pulses"}, wen_cnt - w0, 1);
    chk({tag, "_ren_pulses"}, ren_cnt - r0, 0);
    chk({tag, "_waddr"}, w_addr_seen, a);
    chk({tag, "_wdata"}, w_data_seen, exp_wd);
    chk({tag, "_len"}, w_len_seen, exp_len);
    ack();
  endtask

  initial begin
    int r0, w0, cyc;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_op = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
    rd_val = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_ren", bus.ren, 0);
    chk("rst_wen", bus.wen, 0);
    chk("rst_raddr", bus.raddr, 0);
    chk("rst_waddr", bus.waddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_len", bus.len, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // lb step by step: ISSUE, WAIT, RESP
    rd_val = 32'h0000_0080;
    send(1'b0, OP_B, 32'h8000_0000, 32'h0);
    chk("lb_c1_ren", bus.ren, 1);
    chk("lb_c1_len", bus.len, 1);
    chk("lb_c1_raddr", bus.raddr, 32'h8000_0000);
    chk("lb_c1_valid", bus.resp_valid, 0);
    @(negedge clk);
    chk("lb_c2_ren", bus.ren, 0);
    chk("lb_c2_valid", bus.resp_valid, 0);
    @(negedge clk);
    chk("lb_c3_valid", bus.resp_valid, 1);
    chk("lb_c3_rdata", bus.resp_rdata, 32'hFFFF_FF80);
    chk("lb_c3_req_ready", bus.req_ready, 0);
    ack();
    chk("lb_after_ack_valid", bus.resp_valid, 0);

    load_case("lhu", OP_HU, 32'h8000_0100, 32'h0000_BEEF, 32'h0000_BEEF, 3'd2);
    load_case("lh",  OP_H,  32'h8000_0102, 32'h0000_BEEF, 32'hFFFF_BEEF, 3'd2);
    load_case("lw",  OP_W,  32'h8000_0104, 32'h8765_4321, 32'h8765_4321, 3'd4);
    load_case("lbu", OP_BU, 32'h8000_0105, 32'hFFFF_FFF0, 32'h0000_00F0, 3'd1);
    load_case("lb_pos", OP_B, 32'h8000_0106, 32'h1234_5671, 32'h0000_0071, 3'd1);
    load_case("lh_pos", OP_H, 32'h8000_0108, 32'hFFFF_7FFE, 32'h0000_7FFE, 3'd2);
    load_case("ill011", 3'b011, 32'h8000_010C, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 3'd4);
    load_case("ill110", 3'b110, 32'h8000_0110, 32'h0000_0080, 32'h0000_0080, 3'd4);

    store_case("sb", OP_B, 32'h8000_0003, 32'h1234_5678, 32'h0000_0078, 3'd1);
    store_case("sh", OP_H, 32'h8000_0006, 32'hAABB_CCDD, 32'h0000_CCDD, 3'd2);
    store_case("sw", OP_W, 32'h8000_0008, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3'd4);

    // Response backpressure with a competing request pending
    rd_val = 32'hCAFE_F00D;
    send(1'b0, OP_W, 32'h8000_0020, 32'h0);
    wait_resp(cyc);
    chk("bp_latency", cyc, 3);
    r0 = ren_cnt; w0 = wen_cnt;
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_op = OP_W;
    bus.req_addr = 32'h8000_0040; bus.req_wdata = 32'h1111_2222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", bus.resp_valid, 1);
      chk("bp_rdata", bus.resp_rdata, 32'hCAFE_F00D);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.req_valid = 1'b0;
    chk("bp_no_ren", ren_cnt - r0, 0);
    chk("bp_no_wen", wen_cnt - w0, 0);
    ack();
    chk("bp_done_valid", bus.resp_valid, 0);
    chk("bp_done_ready", bus.req_ready, 1);

    // Asynchronous reset while waiting on read data
    rd_val = 32'h5555_AAAA;
    r0 = ren_cnt;
    send(1'b0, OP_H, 32'h8000_0010, 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_raddr", bus.raddr, 0);
    chk("arst_len", bus.len, 0);
    chk("arst_ren", bus.ren, 0);
    chk("arst_req_ready", bus.req_ready, 1);
    chk("arst_resp_valid", bus.resp_valid, 0);
    chk("arst_resp_rdata", bus.resp_rdata, 0);
    repeat (2) @(negedge clk);
    chk("arst_hold_valid", bus.resp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_ren_once", ren_cnt - r0, 1);
    chk("arst_no_resp", bus.resp_valid, 0);
    load_case("post_rst_lb", OP_B, 32'h8000_0030, 32'h0000_00FF, 32'hFFFF_FFFF, 3'd1);

    // Misaligned word load
    r0 = ren_cnt;
    rd_val = 32'h0BAD_CAFE;
    send(1'b0, OP_W, 32'h8000_0002, 32'h0);
    wait_resp(cyc);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_latency", cyc, 1);
    chk("mis_err", bus.resp_err, 1);
    chk("mis_rdata", bus.resp_rdata, 0);
    chk("mis_ren", ren_cnt - r0, 0);
`else
    chk("mis_latency", cyc, 3);
    chk("mis_err", bus.resp_err, 0);
    chk("mis_rdata", bus.resp_rdata, 32'h0BAD_CAFE);
    chk("mis_ren", ren_cnt - r0, 1);
`endif
    ack();

    chk("ren_wen_overlap", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
